// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target register bank.
//   - i2c_state_e   : target protocol state enumeration
//   - I2C_ACK/NACK  : level of the acknowledge bit on the bus
//   - SDA_DRIVE_LOW / SDA_RELEASE : open-drain enable encoding (shared with the master)
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_ADDR_ACK,
    ST_RX_OFFSET,
    ST_OFFSET_ACK,
    ST_RX_DATA,
    ST_DATA_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic SDA_DRIVE_LOW = 1'b0;
  localparam logic SDA_RELEASE   = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditions one raw bus line.
//   2-FF synchroniser, then a stability filter that only moves the filtered
//   level after FILTER_LEN consecutive samples disagree with it, then edge
//   detect. Total latency raw -> o_level is 2+FILTER_LEN cycles; the edge
//   pulses are aligned with the cycle the filtered level changes.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_raw          : raw asynchronous line
//   o_level        : filtered level (resets to 1, idle bus)
//   o_rise, o_fall : one-cycle pulses on filtered level changes
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // r_cnt counts how many consecutive samples already disagreed; any
      // agreeing sample restarts the count, so short glitches never pass.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target emulating a redriver register bank.
//   Matches SLAVE_ADDR, latches a 1-byte offset, then burst write or burst
//   read with an auto-incrementing, wrapping pointer. No clock stretching.
// Ports:
//   iClk, iRstn   : system clock (>=10x SCL), asynchronous active-low reset
//   iSCL, iSDA    : raw bus lines
//   oSDAOE        : SDA enable, active low (0 drives low, 1 releases)
//   ivLocalAddr   : local read address
//   ovLocalData   : register[ivLocalAddr], 1-cycle latency
//   oWrStb        : one-cycle pulse per register written over I2C
//   ovWrAddr      : offset of the flagged write
//   ovWrData      : data of the flagged write
//   oBusy         : high from an address-matched START until STOP
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h58,
  parameter int unsigned REG_DEPTH  = 64,
  parameter int unsigned FILTER_LEN = 3,
  parameter logic [7:0]  REG_RESET  = 8'h00,
  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
  input  logic          iClk,
  input  logic          iRstn,
  input  logic          iSCL,
  input  logic          iSDA,
  output logic          oSDAOE,
  input  logic [AW-1:0] ivLocalAddr,
  output logic [7:0]    ovLocalData,
  output logic          oWrStb,
  output logic [AW-1:0] ovWrAddr,
  output logic [7:0]    ovWrData,
  output logic          oBusy
);

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .i_clk   (iClk),
    .i_rst_n (iRstn),
    .i_raw   (iSCL),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .i_clk   (iClk),
    .i_rst_n (iRstn),
    .i_raw   (iSDA),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // Both lines share the filter latency, so their relative timing is kept.
  logic w_start;
  logic w_stop;
  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_e    r_state;
  i2c_state_e    w_state_nxt;
  logic [3:0]    r_bitcnt;
  logic [3:0]    w_bitcnt_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic          r_rw;
  logic          w_rw_nxt;
  logic          r_sdaoe;
  logic          w_sdaoe_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          w_wr_en;

  logic [7:0]    r_regs [REG_DEPTH];
  logic [7:0]    w_rd_byte;
  logic [AW-1:0] w_ptr_inc;
  logic          w_rx_shift;
  logic          w_rx_done;

  logic          r_wrstb;
  logic [AW-1:0] r_wraddr;
  logic [7:0]    r_wrdata;
  logic [7:0]    r_localdata;

  assign w_rd_byte  = r_regs[r_ptr];
  assign w_ptr_inc  = (r_ptr == AW'(REG_DEPTH - 1)) ? '0 : r_ptr + AW'(1);
  // Receive states sample on SCL rise; the 8th bit is acted on at the
  // following SCL fall so the ACK is driven while SCL is low.
  assign w_rx_shift = w_scl_rise && (r_bitcnt != 4'd8);
  assign w_rx_done  = w_scl_fall && (r_bitcnt == 4'd8);

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_rw     <= 1'b0;
      r_sdaoe  <= SDA_RELEASE;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rw     <= w_rw_nxt;
      r_sdaoe  <= w_sdaoe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_rw_nxt     = r_rw;
    w_sdaoe_nxt  = r_sdaoe;
    w_busy_nxt   = r_busy;
    w_wr_en      = 1'b0;

    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_sdaoe_nxt = SDA_RELEASE;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      // Covers repeated START too; the pointer is deliberately kept.
      w_state_nxt  = ST_RX_ADDR;
      w_bitcnt_nxt = '0;
      w_sdaoe_nxt  = SDA_RELEASE;
    end else begin
      unique case (r_state)
        ST_IDLE: ;

        ST_RX_ADDR: begin
          if (w_rx_shift) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_rx_done) begin
            w_bitcnt_nxt = '0;
            if (r_shift[7:1] == SLAVE_ADDR) begin
              w_state_nxt = ST_ADDR_ACK;
              w_sdaoe_nxt = SDA_DRIVE_LOW;
              w_busy_nxt  = 1'b1;
              w_rw_nxt    = r_shift[0];
              if (r_shift[0]) w_shift_nxt = w_rd_byte;
            end else begin
              w_state_nxt = ST_IGNORE;
              w_sdaoe_nxt = SDA_RELEASE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_nxt  = ST_TX_DATA;
              w_sdaoe_nxt  = r_shift[7];
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_bitcnt_nxt = 4'd1;
            end else begin
              w_state_nxt  = ST_RX_OFFSET;
              w_sdaoe_nxt  = SDA_RELEASE;
              w_bitcnt_nxt = '0;
            end
          end
        end

        ST_RX_OFFSET: begin
          if (w_rx_shift) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_rx_done) begin
            w_bitcnt_nxt = '0;
            if (32'(r_shift) < REG_DEPTH) begin
              w_ptr_nxt   = AW'(r_shift);
              w_state_nxt = ST_OFFSET_ACK;
              w_sdaoe_nxt = SDA_DRIVE_LOW;
            end else begin
              w_state_nxt = ST_IGNORE;
              w_sdaoe_nxt = SDA_RELEASE;
            end
          end
        end

        ST_OFFSET_ACK, ST_DATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = ST_RX_DATA;
            w_sdaoe_nxt  = SDA_RELEASE;
            w_bitcnt_nxt = '0;
          end
        end

        ST_RX_DATA: begin
          if (w_rx_shift) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_rx_done) begin
            w_wr_en      = 1'b1;
            w_ptr_nxt    = w_ptr_inc;
            w_bitcnt_nxt = '0;
            w_state_nxt  = ST_DATA_ACK;
            w_sdaoe_nxt  = SDA_DRIVE_LOW;
          end
        end

        ST_TX_DATA: begin
          // r_bitcnt counts bits already placed on the bus.
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_state_nxt = ST_TX_ACK;
              w_sdaoe_nxt = SDA_RELEASE;
              w_ptr_nxt   = w_ptr_inc;
            end else begin
              w_sdaoe_nxt  = r_shift[7];
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end

        ST_TX_ACK: begin
          // A NACK ends the read at the rise; a fall here implies an ACK.
          if (w_scl_rise && (w_sda == I2C_NACK)) begin
            w_state_nxt = ST_IGNORE;
          end else if (w_scl_fall) begin
            w_state_nxt  = ST_TX_DATA;
            w_sdaoe_nxt  = w_rd_byte[7];
            w_shift_nxt  = {w_rd_byte[6:0], 1'b0};
            w_bitcnt_nxt = 4'd1;
          end
        end

        ST_IGNORE: ;

        default: begin
          w_state_nxt = ST_IDLE;
          w_sdaoe_nxt = SDA_RELEASE;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) r_regs[i] <= REG_RESET;
    end else if (w_wr_en) begin
      r_regs[r_ptr] <= r_shift;
    end
  end

  // Local read samples the array before this cycle's write lands, so a
  // same-cycle collision shows the old value first.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_wrstb     <= 1'b0;
      r_wraddr    <= '0;
      r_wrdata    <= '0;
      r_localdata <= '0;
    end else begin
      r_wrstb     <= w_wr_en;
      r_localdata <= r_regs[ivLocalAddr];
      if (w_wr_en) begin
        r_wraddr <= r_ptr;
        r_wrdata <= r_shift;
      end
    end
  end

  assign oSDAOE      = r_sdaoe;
  assign oBusy       = r_busy;
  assign oWrStb      = r_wrstb;
  assign ovWrAddr    = r_wraddr;
  assign ovWrData    = r_wrdata;
  assign ovLocalData = r_localdata;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master on an open-drain SDA,
// table of write transactions plus hand-written read / abort / glitch /
// reset sequences.
module tb_i2c_slave_regfile;

  localparam int unsigned QC = 20;  // clock cycles per quarter SCL period

  logic       iClk = 1'b0;
  logic       iRstn = 1'b0;
  logic       r_scl = 1'b1;
  logic       r_sda_m = 1'b1;
  logic       w_sda;
  logic       oSDAOE;
  logic [5:0] ivLocalAddr = '0;
  logic [7:0] ovLocalData;
  logic       oWrStb;
  logic [5:0] ovWrAddr;
  logic [7:0] ovWrData;
  logic       oBusy;
  logic       glitch_en = 1'b0;

  assign w_sda = r_sda_m & oSDAOE;

  always #5 iClk = ~iClk;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h58),
    .REG_DEPTH  (64),
    .FILTER_LEN (3),
    .REG_RESET  (8'h00)
  ) dut (
    .iClk        (iClk),
    .iRstn       (iRstn),
    .iSCL        (r_scl),
    .iSDA        (w_sda),
    .oSDAOE      (oSDAOE),
    .ivLocalAddr (ivLocalAddr),
    .ovLocalData (ovLocalData),
    .oWrStb      (oWrStb),
    .ovWrAddr    (ovWrAddr),
    .ovWrData    (ovWrData),
    .oBusy       (oBusy)
  );

  // Monitor: logs every write strobe and counts cycles with SDA driven.
  logic [13:0] stb_q[$];
  int          n_drive = 0;
  always @(negedge iClk) begin
    if (oWrStb === 1'b1) stb_q.push_back({ovWrAddr, ovWrData});
    if (oSDAOE === 1'b0) n_drive++;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold();
    repeat (QC) @(negedge iClk);
  endtask

  task automatic bus_start();
    r_sda_m = 1'b1; hold();
    r_scl = 1'b1;   hold();
    r_sda_m = 1'b0; hold();
    r_scl = 1'b0;   hold();
  endtask

  task automatic bus_stop();
    r_sda_m = 1'b0; hold();
    r_scl = 1'b1;   hold();
    r_sda_m = 1'b1; hold();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    r_sda_m = b; hold();
    r_scl = 1'b1;
    repeat (QC/2) @(negedge iClk);
    if (glitch_en) begin
      r_sda_m = ~b;
      @(negedge iClk);
      r_sda_m = b;
    end else begin
      @(negedge iClk);
    end
    repeat (QC/2 - 1) @(negedge iClk);
    s = w_sda;
    hold();
    r_scl = 1'b0; hold();
  endtask

  // acked = 1 when the target pulled SDA low in the 9th clock
  task automatic write_byte(input logic [7:0] v, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
    bus_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic s;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      v = {v[6:0], s};
    end
    bus_bit(nack, s);
  endtask

  task automatic local_read(input logic [5:0] a, output logic [7:0] v);
    ivLocalAddr = a;
    @(negedge iClk);
    @(negedge iClk);
    v = ovLocalData;
  endtask

  typedef struct packed {
    logic [7:0]      dev;
    logic [7:0]      off;
    logic [1:0]      n;
    logic [2:0][7:0] d;
    logic            dev_ack;
    logic            off_ack;
    logic [1:0]      n_stb;
    logic [2:0][5:0] ca;
    logic [2:0][7:0] cv;
  } vec_t;

  vec_t tbl [4];

  initial begin
    repeat (4000000) @(posedge iClk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] v;
    int         base_stb;
    int         base_drv;
    logic [7:0] addr_b;

    // dev, off, n, data{d2,d1,d0}, dev_ack, off_ack, n_stb, check addrs, check vals
    tbl[0] = '{dev:8'hB0, off:8'h0E, n:2'd3, d:{8'hAE, 8'h2D, 8'h04}, dev_ack:1'b1, off_ack:1'b1,
               n_stb:2'd3, ca:{6'h10, 6'h0F, 6'h0E}, cv:{8'hAE, 8'h2D, 8'h04}};
    tbl[1] = '{dev:8'hB2, off:8'h0E, n:2'd1, d:{8'h00, 8'h00, 8'h55}, dev_ack:1'b0, off_ack:1'b0,
               n_stb:2'd0, ca:{6'h10, 6'h0F, 6'h0E}, cv:{8'hAE, 8'h2D, 8'h04}};
    tbl[2] = '{dev:8'hB0, off:8'h40, n:2'd1, d:{8'h00, 8'h00, 8'h99}, dev_ack:1'b1, off_ack:1'b0,
               n_stb:2'd0, ca:{6'h0E, 6'h3F, 6'h00}, cv:{8'h04, 8'h00, 8'h00}};
    tbl[3] = '{dev:8'hB0, off:8'h3F, n:2'd2, d:{8'h00, 8'h22, 8'h11}, dev_ack:1'b1, off_ack:1'b1,
               n_stb:2'd2, ca:{6'h01, 6'h00, 6'h3F}, cv:{8'h00, 8'h22, 8'h11}};

    // Reset state
    repeat (5) @(negedge iClk);
    check("rst oSDAOE", oSDAOE, 1'b1);
    check("rst oWrStb", oWrStb, 1'b0);
    check("rst ovWrAddr", ovWrAddr, 6'h00);
    check("rst ovWrData", ovWrData, 8'h00);
    check("rst ovLocalData", ovLocalData, 8'h00);
    check("rst oBusy", oBusy, 1'b0);
    iRstn = 1'b1;
    hold();

    for (int r = 0; r < 4; r++) begin
      base_stb = stb_q.size();
      base_drv = n_drive;
      bus_start();
      write_byte(tbl[r].dev, ack);
      check($sformatf("v%0d dev_ack", r), ack, tbl[r].dev_ack);
      write_byte(tbl[r].off, ack);
      check($sformatf("v%0d off_ack", r), ack, tbl[r].off_ack);
      for (int i = 0; i < int'(tbl[r].n); i++) begin
        write_byte(tbl[r].d[i], ack);
        check($sformatf("v%0d data%0d_ack", r, i), ack, tbl[r].off_ack);
      end
      bus_stop();
      hold();
      check($sformatf("v%0d strobes", r), stb_q.size() - base_stb, tbl[r].n_stb);
      for (int i = 0; i < int'(tbl[r].n_stb); i++) begin
        if (base_stb + i < stb_q.size()) begin
          check($sformatf("v%0d stb%0d addr", r, i), stb_q[base_stb+i][13:8], 6'(tbl[r].off + 8'(i)));
          check($sformatf("v%0d stb%0d data", r, i), stb_q[base_stb+i][7:0], tbl[r].d[i]);
        end
      end
      if (!tbl[r].dev_ack)
        check($sformatf("v%0d sda_never_driven", r), n_drive - base_drv, 0);
      for (int k = 0; k < 3; k++) begin
        local_read(tbl[r].ca[k], v);
        check($sformatf("v%0d reg[%0h]", r, tbl[r].ca[k]), v, tbl[r].cv[k]);
      end
      check($sformatf("v%0d busy_after_stop", r), oBusy, 1'b0);
    end

    // Offset write, repeated START, burst read of 3 with ACK ACK NACK
    bus_start();
    write_byte(8'hB0, ack); check("rd wr_addr_ack", ack, 1'b1);
    write_byte(8'h0E, ack); check("rd offset_ack", ack, 1'b1);
    bus_start();
    write_byte(8'hB1, ack); check("rd rd_addr_ack", ack, 1'b1);
    check("rd busy", oBusy, 1'b1);
    read_byte(1'b0, v); check("rd byte0", v, 8'h04);
    read_byte(1'b0, v); check("rd byte1", v, 8'h2D);
    read_byte(1'b1, v); check("rd byte2", v, 8'hAE);
    hold();
    check("rd released_after_nack", oSDAOE, 1'b1);
    bus_stop();
    hold();
    check("rd busy_after_stop", oBusy, 1'b0);

    // STOP after 4 data bits: partial byte discarded
    base_stb = stb_q.size();
    bus_start();
    write_byte(8'hB0, ack); check("abort addr_ack", ack, 1'b1);
    write_byte(8'h0E, ack); check("abort off_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
    bus_stop();
    hold();
    check("abort strobes", stb_q.size() - base_stb, 0);
    local_read(6'h0E, v); check("abort reg[0E]", v, 8'h04);

    // 1-cycle SDA glitch during every SCL-high phase of a write
    base_stb = stb_q.size();
    glitch_en = 1'b1;
    bus_start();
    write_byte(8'hB0, ack); check("glitch addr_ack", ack, 1'b1);
    write_byte(8'h20, ack); check("glitch off_ack", ack, 1'b1);
    write_byte(8'h5A, ack); check("glitch data_ack", ack, 1'b1);
    glitch_en = 1'b0;
    bus_stop();
    hold();
    check("glitch strobes", stb_q.size() - base_stb, 1);
    local_read(6'h20, v); check("glitch reg[20]", v, 8'h5A);

    // Asynchronous reset while the target drives the address ACK
    addr_b = 8'hB0;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(addr_b[i], s);
    r_sda_m = 1'b1; hold();
    r_scl = 1'b1;
    repeat (QC/2) @(negedge iClk);
    check("ack driven before reset", oSDAOE, 1'b0);
    #2 iRstn = 1'b0;
    #1 check("async reset releases SDA", oSDAOE, 1'b1);
    repeat (3) @(negedge iClk);
    iRstn = 1'b1;
    hold();
    r_scl = 1'b0; hold();
    bus_stop();
    hold();
    check("post-reset busy", oBusy, 1'b0);
    local_read(6'h0E, v); check("post-reset reg[0E]", v, 8'h00);
    local_read(6'h20, v); check("post-reset reg[20]", v, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
